alu_exec: RTL and testbench

- Execution stage directly downstream of the reservation station.
- Accepts one issued arithmetic/branch/jump op per cycle: op code, two operands and the destination ROB index.
- Computes the result and queues it in a small result FIFO.
- Broadcasts the FIFO head on the ALU result bus when granted. RS, LSB and ROB consume this as the "RS update" (flag/idx/value) channel.

---
 rtl/alu_exec_pkg.sv | 48 ++++
 rtl/alu_exec_if.sv | 42 ++++
 rtl/alu_exec_core.sv | 66 ++++++
 rtl/alu_exec.sv | 113 +++++++++++
 tb/tb_alu_exec.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_pkg.sv
// ============================================================================
//  Module      : alu_exec_pkg
//  Description : Shared widths and op-code encoding for the ALU execution
//                stage (same encoding as the RS / decoder op field).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_exec_pkg;

  // Default widths for the execution datapath
  localparam int XLEN_DEF       = 32;
  localparam int INS_W_DEF      = 6;
  localparam int ROB_W_DEF      = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  // Op codes; 0 and 2 are not ALU ops and produce a zero result
  localparam logic [INS_W_DEF-1:0] OP_LUI   = 6'd1;
  localparam logic [INS_W_DEF-1:0] OP_JALR  = 6'd3;
  localparam logic [INS_W_DEF-1:0] OP_BEQ   = 6'd4;
  localparam logic [INS_W_DEF-1:0] OP_BNE   = 6'd5;
  localparam logic [INS_W_DEF-1:0] OP_BLT   = 6'd6;
  localparam logic [INS_W_DEF-1:0] OP_BGE   = 6'd7;
  localparam logic [INS_W_DEF-1:0] OP_BLTU  = 6'd8;
  localparam logic [INS_W_DEF-1:0] OP_BGEU  = 6'd9;
  localparam logic [INS_W_DEF-1:0] OP_ADDI  = 6'd10;
  localparam logic [INS_W_DEF-1:0] OP_SLTI  = 6'd11;
  localparam logic [INS_W_DEF-1:0] OP_SLTIU = 6'd12;
  localparam logic [INS_W_DEF-1:0] OP_XORI  = 6'd13;
  localparam logic [INS_W_DEF-1:0] OP_ORI   = 6'd14;
  localparam logic [INS_W_DEF-1:0] OP_ANDI  = 6'd15;
  localparam logic [INS_W_DEF-1:0] OP_SLLI  = 6'd16;
  localparam logic [INS_W_DEF-1:0] OP_SRLI  = 6'd17;
  localparam logic [INS_W_DEF-1:0] OP_SRAI  = 6'd18;
  localparam logic [INS_W_DEF-1:0] OP_ADD   = 6'd19;
  localparam logic [INS_W_DEF-1:0] OP_SUB   = 6'd20;
  localparam logic [INS_W_DEF-1:0] OP_SLL   = 6'd21;
  localparam logic [INS_W_DEF-1:0] OP_SLT   = 6'd22;
  localparam logic [INS_W_DEF-1:0] OP_SLTU  = 6'd23;
  localparam logic [INS_W_DEF-1:0] OP_XOR   = 6'd24;
  localparam logic [INS_W_DEF-1:0] OP_SRL   = 6'd25;
  localparam logic [INS_W_DEF-1:0] OP_SRA   = 6'd26;
  localparam logic [INS_W_DEF-1:0] OP_OR    = 6'd27;
  localparam logic [INS_W_DEF-1:0] OP_AND   = 6'd28;

endpackage

`default_nettype wire

// File: rtl/alu_exec_if.sv
// ============================================================================
//  Module      : alu_exec_if
//  Description : Issue (RS -> ALU) and result-bus (ALU -> RS/LSB/ROB)
//                signals of the ALU execution stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_exec_if
  import alu_exec_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int INS_W = INS_W_DEF,
  parameter int ROB_W = ROB_W_DEF
);

  logic             in_valid;
  logic [INS_W-1:0] in_insty;
  logic [XLEN-1:0]  in_val1;
  logic [XLEN-1:0]  in_val2;
  logic [ROB_W-1:0] in_rob_idx;
  logic             in_ready;
  logic             out_valid;
  logic [ROB_W-1:0] out_rob_idx;
  logic [XLEN-1:0]  out_val;
  logic             cdb_grant;

  // Issuer and result consumers
  modport master (
    output in_valid, in_insty, in_val1, in_val2, in_rob_idx, cdb_grant,
    input  in_ready, out_valid, out_rob_idx, out_val
  );

  // ALU execution stage
  modport slave (
    input  in_valid, in_insty, in_val1, in_val2, in_rob_idx, cdb_grant,
    output in_ready, out_valid, out_rob_idx, out_val
  );

endinterface

`default_nettype wire

// File: rtl/alu_exec_core.sv
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational op-code/operands -> result function.
//                Branches return 1 when taken, 0 otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
  import alu_exec_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int INS_W = INS_W_DEF
) (
  input  logic [INS_W-1:0] insty,
  input  logic [XLEN-1:0]  val1,
  input  logic [XLEN-1:0]  val2,
  output logic [XLEN-1:0]  result
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] sum;
  logic            lt_s;
  logic            lt_u;
  logic            eq;

  // Shared adder, comparators and shift amount used by several op groups
  always_comb begin
    shamt = val2[SH_W-1:0];
    sum   = val1 + val2;
    lt_s  = $signed(val1) < $signed(val2);
    lt_u  = val1 < val2;
    eq    = (val1 == val2);
  end

  // Op-code decode into the final result; unknown codes give zero
  always_comb begin
    result = '0;
    case (insty)
      OP_ADD, OP_ADDI:   result = sum;
      OP_SUB:            result = val1 - val2;
      OP_AND, OP_ANDI:   result = val1 & val2;
      OP_OR,  OP_ORI:    result = val1 | val2;
      OP_XOR, OP_XORI:   result = val1 ^ val2;
      OP_SLL, OP_SLLI:   result = val1 << shamt;
      OP_SRL, OP_SRLI:   result = val1 >> shamt;
      OP_SRA, OP_SRAI:   result = $unsigned($signed(val1) >>> shamt);
      OP_SLT, OP_SLTI:   result = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU, OP_SLTIU: result = {{(XLEN-1){1'b0}}, lt_u};
      OP_BEQ:            result = {{(XLEN-1){1'b0}}, eq};
      OP_BNE:            result = {{(XLEN-1){1'b0}}, ~eq};
      OP_BLT:            result = {{(XLEN-1){1'b0}}, lt_s};
      OP_BGE:            result = {{(XLEN-1){1'b0}}, ~lt_s};
      OP_BLTU:           result = {{(XLEN-1){1'b0}}, lt_u};
      OP_BGEU:           result = {{(XLEN-1){1'b0}}, ~lt_u};
      OP_JALR:           result = sum & ~{{(XLEN-1){1'b0}}, 1'b1};
      OP_LUI:            result = val2;
      default:           result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
//  Module      : alu_exec
//  Description : ALU execution stage. Computes the issued op and queues
//                {rob_idx, result} in a small FIFO whose head is broadcast
//                on the result bus until the consumer grants it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int INS_W      = INS_W_DEF,
  parameter int ROB_W      = ROB_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       jp_wrong,
  alu_exec_if.slave  bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ROB_W + XLEN;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [FIFO_DEPTH-1:0][ENTRY_W-1:0] mem_q, mem_d;

  logic [XLEN-1:0]    alu_result;
  logic [ENTRY_W-1:0] head_entry;
  logic               in_ready;
  logic               out_valid;
  logic               push;
  logic               pop;

  alu_core #(
    .XLEN  (XLEN),
    .INS_W (INS_W)
  ) u_core (
    .insty  (bus.in_insty),
    .val1   (bus.in_val1),
    .val2   (bus.in_val2),
    .result (alu_result)
  );

  // Flags come from the registered count only, so a full queue never
  // accepts even when the head is popped in the same cycle.
  assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign out_valid  = (count_q != '0);
  assign push       = rdy & ~jp_wrong & bus.in_valid & in_ready;
  assign pop        = rdy & ~jp_wrong & out_valid & bus.cdb_grant;
  assign head_entry = mem_q[head_q];

  // Head fields are masked while empty so stale storage never shows
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_rob_idx = out_valid ? head_entry[ENTRY_W-1:XLEN] : '0;
  assign bus.out_val     = out_valid ? head_entry[XLEN-1:0] : '0;

  // Next pointers/count; a flush overrides any same-cycle push and pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy) begin
      if (jp_wrong) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Next storage contents: write the new entry at the tail on a push
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[tail_q] = {bus.in_rob_idx, alu_result};
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Result storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
//  Module      : tb_alu_exec
//  Description : Scoreboard bench for alu_exec with directed and random ops.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;
  import alu_exec_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  logic jp_wrong = 1'b0;
  logic mon_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];

  alu_exec_if #(.XLEN(32), .INS_W(6), .ROB_W(4)) bus ();

  alu_exec #(.XLEN(32), .INS_W(6), .ROB_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .jp_wrong (jp_wrong),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model straight from the op definitions, using integer arithmetic
  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua, ub, p2;
    longint sa, sb, q;
    ua = a;
    ub = b;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    p2 = 64'd1 << (ub % 32);
    case (op)
      OP_ADD, OP_ADDI:   return 32'(ua + ub);
      OP_SUB:            return 32'(ua + 64'h1_0000_0000 - ub);
      OP_AND, OP_ANDI:   return a & b;
      OP_OR,  OP_ORI:    return a | b;
      OP_XOR, OP_XORI:   return a ^ b;
      OP_SLL, OP_SLLI:   return 32'(ua * p2);
      OP_SRL, OP_SRLI:   return 32'(ua / p2);
      OP_SRA, OP_SRAI: begin
        if (sa >= 0) q = sa / longint'(p2);
        else q = -((-sa + longint'(p2) - 1) / longint'(p2));
        return 32'(q);
      end
      OP_SLT, OP_SLTI:   return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU, OP_SLTIU: return (ua < ub) ? 32'd1 : 32'd0;
      OP_BEQ:            return (ua == ub) ? 32'd1 : 32'd0;
      OP_BNE:            return (ua != ub) ? 32'd1 : 32'd0;
      OP_BLT:            return (sa < sb) ? 32'd1 : 32'd0;
      OP_BGE:            return (sa >= sb) ? 32'd1 : 32'd0;
      OP_BLTU:           return (ua < ub) ? 32'd1 : 32'd0;
      OP_BGEU:           return (ua >= ub) ? 32'd1 : 32'd0;
      OP_JALR:           return 32'(((ua + ub) % 64'h1_0000_0000) / 2 * 2);
      OP_LUI:            return b;
      default:           return 32'd0;
    endcase
  endfunction

  // One issue cycle; the expected entry joins the scoreboard once the edge commits it
  task automatic cyc(input logic v, input logic [5:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [3:0] rob, input logic g,
                     input logic r, input logic j);
    bit   acc;
    exp_t e;
    bus.in_valid   = v;
    bus.in_insty   = op;
    bus.in_val1    = a;
    bus.in_val2    = b;
    bus.in_rob_idx = rob;
    bus.cdb_grant  = g;
    rdy            = r;
    jp_wrong       = j;
    acc   = r && !j && v && (exp_q.size() != DEPTH);
    e.rob = rob;
    e.val = ref_alu(op, a, b);
    @(posedge clk);
    #2;
    if (acc) exp_q.push_back(e);
  endtask

  task automatic idle(input logic g);
    cyc(1'b0, 6'd0, 32'd0, 32'd0, 4'd0, g, 1'b1, 1'b0);
  endtask

  // Monitor: checks flags and head every cycle, pops on a granted broadcast
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mon_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() != DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("out_rob_idx", 32'(bus.out_rob_idx), 32'(e.rob));
        chk("out_val", bus.out_val, e.val);
      end
      if (rdy) begin
        if (jp_wrong) exp_q.delete();
        else if (bus.cdb_grant && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    rdy   = 1'b1;
  endtask

  logic [5:0] ops [27];

  initial begin
    ops = '{OP_LUI, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI,
            OP_SRAI, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
            OP_SRA, OP_OR, OP_AND};
    bus.in_valid   = 1'b0;
    bus.in_insty   = '0;
    bus.in_val1    = '0;
    bus.in_val2    = '0;
    bus.in_rob_idx = '0;
    bus.cdb_grant  = 1'b0;

    do_reset();
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_val", bus.out_val, 32'd0);
    chk("reset out_rob_idx", 32'(bus.out_rob_idx), 32'd0);
    mon_en = 1'b1;
    idle(1'b0);

    // Wrapping add, one-cycle latency, popped under grant
    cyc(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back ops at full throughput
    cyc(1'b1, OP_SRA,  32'h8000_0000, 32'd4,        4'd5, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, OP_SLTU, 32'd1,         32'hFFFF_FFFF, 4'd6, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, OP_BGE,  32'hFFFF_FFFF, 32'd0,        4'd7, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, OP_JALR, 32'h0000_1001, 32'd4,        4'd8, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill with no grant, fifth issue dropped, then drain in order
    for (int i = 1; i <= 5; i++)
      cyc(1'b1, OP_ADDI, 32'(i * 100), 32'd7, 4'(i), 1'b0, 1'b1, 1'b0);
    repeat (5) idle(1'b1);

    // Flush with two queued entries plus a same-cycle issue and grant
    cyc(1'b1, OP_XOR, 32'h1234_5678, 32'hFFFF_0000, 4'd9, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, OP_OR,  32'h0F0F_0000, 32'h0000_F0F0, 4'd10, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, OP_SUB, 32'd0, 32'd1, 4'd11, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Hold with rdy low while issue and grant stay high
    cyc(1'b1, OP_SLT, 32'h8000_0000, 32'd1, 4'd12, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, OP_LUI, 32'd0, 32'hABCD_E000, 4'd13, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, OP_SLL, 32'd3, 32'd31, 4'd14, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges clears the queue immediately
    bus.in_valid = 1'b0;
    bus.cdb_grant = 1'b0;
    rdy = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("async reset in_ready", 32'(bus.in_ready), 32'd1);
    do_reset();
    mon_en = 1'b1;
    idle(1'b0);

    // Randomised traffic with occasional stalls, flushes and undefined codes
    for (int n = 0; n < 600; n++) begin
      logic [5:0]  op;
      logic [31:0] a, b;
      if ($urandom_range(9) == 0) op = 6'($urandom_range(63));
      else op = ops[$urandom_range(26)];
      case ($urandom_range(3))
        0: a = 32'hFFFF_FFFF;
        1: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(4))
        0: b = 32'h0000_0000;
        1: b = 32'h7FFF_FFFF;
        2: b = 32'($urandom_range(31));
        default: b = $urandom;
      endcase
      cyc($urandom_range(3) != 0, op, a, b, 4'($urandom_range(15)),
          $urandom_range(2) != 0, $urandom_range(7) != 0, $urandom_range(31) == 0);
    end
    repeat (6) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
